// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-slot data-memory arbiter. Slot0 (older) always reaches the
//               memory port first; a same-cycle slot1 request is parked in a
//               hold register and issued in the following cycle (HOLD1).
//               Tracks dual-request cycles and flags read+write requests.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  // slot0 (older) request
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [31:0]       req0_wdata_i,
  input  logic [3:0]        req0_we_i,
  input  logic              req0_re_i,
  // slot1 (younger) request
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [31:0]       req1_wdata_i,
  input  logic [3:0]        req1_we_i,
  input  logic              req1_re_i,
  // responses
  output logic              rsp0_valid_o,
  output logic [31:0]       rsp0_rdata_o,
  output logic              rsp1_valid_o,
  output logic [31:0]       rsp1_rdata_o,
  // memory port
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_we_o,
  output logic              mem_re_o,
  input  logic [31:0]       mem_rdata_i,
  // status
  output logic              busy_o,
  output logic [CNT_W-1:0]  conflict_cnt_o,
  output logic              err_o
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_HOLD1 = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e              state_q;
  logic [ADDR_W-1:0]   hold_addr_q;
  logic [31:0]         hold_wdata_q;
  logic [3:0]          hold_we_q;
  logic                hold_re_q;
  logic [1:0]          rsp_pend_q;   // bit N: slot N has a read in flight
  logic [CNT_W-1:0]    cnt_q;
  logic                err_q;

  logic [ADDR_W-1:0]   w_sel_addr;
  logic [31:0]         w_sel_wdata;
  logic [3:0]          w_sel_we;
  logic                w_sel_re;
  logic                w_sel_any;
  logic                w_sel_slot1;
  logic                w_rdy0;
  logic                w_rdy1;
  logic                w_is_wr;
  logic                w_is_rd;
  logic                w_conflict;
  logic                w_bad;

  // Pick the request that owns the memory port this cycle (hold register wins in HOLD1).
  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_we    = '0;
    w_sel_re    = 1'b0;
    w_sel_any   = 1'b0;
    w_sel_slot1 = 1'b0;
    w_rdy0      = 1'b0;
    w_rdy1      = 1'b0;
    if (rst_n) begin
      if (state_q == S_HOLD1) begin
        w_sel_addr  = hold_addr_q;
        w_sel_wdata = hold_wdata_q;
        w_sel_we    = hold_we_q;
        w_sel_re    = hold_re_q;
        w_sel_any   = 1'b1;
        w_sel_slot1 = 1'b1;
      end else if (req0_valid_i) begin
        w_sel_addr  = req0_addr_i;
        w_sel_wdata = req0_wdata_i;
        w_sel_we    = req0_we_i;
        w_sel_re    = req0_re_i;
        w_sel_any   = 1'b1;
        w_rdy0      = 1'b1;
        w_rdy1      = req1_valid_i;
      end else if (req1_valid_i) begin
        w_sel_addr  = req1_addr_i;
        w_sel_wdata = req1_wdata_i;
        w_sel_we    = req1_we_i;
        w_sel_re    = req1_re_i;
        w_sel_any   = 1'b1;
        w_sel_slot1 = 1'b1;
        w_rdy1      = 1'b1;
      end
    end
  end

  // Any byte enable makes it a write; a read is issued only when no enable is set.
  assign w_is_wr    = w_sel_any & (|w_sel_we);
  assign w_is_rd    = w_sel_any & ~(|w_sel_we) & w_sel_re;
  assign w_conflict = w_rdy0 & w_rdy1;
  assign w_bad      = (w_rdy0 & req0_re_i & (|req0_we_i)) |
                      (w_rdy1 & req1_re_i & (|req1_we_i));

  // Controller state, hold register, response tracking and status counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      hold_we_q    <= '0;
      hold_re_q    <= 1'b0;
      rsp_pend_q   <= 2'b00;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE:  state_q <= w_conflict ? S_HOLD1 : S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      if (w_conflict) begin
        hold_addr_q  <= req1_addr_i;
        hold_wdata_q <= req1_wdata_i;
        hold_we_q    <= req1_we_i;
        hold_re_q    <= req1_re_i;
        if (cnt_q != C_CNT_MAX) begin
          cnt_q <= cnt_q + C_CNT_ONE;
        end
      end
      rsp_pend_q <= {w_is_rd & w_sel_slot1, w_is_rd & ~w_sel_slot1};
      if (w_bad) begin
        err_q <= 1'b1;
      end
    end
  end

  // All outputs are forced low while reset is held.
  assign req0_ready_o   = w_rdy0;
  assign req1_ready_o   = w_rdy1;
  assign mem_addr_o     = (w_is_wr | w_is_rd) ? w_sel_addr : '0;
  assign mem_wdata_o    = w_is_wr ? w_sel_wdata : 32'h0;
  assign mem_we_o       = w_is_wr ? w_sel_we : 4'h0;
  assign mem_re_o       = w_is_rd;
  assign rsp0_valid_o   = rst_n & rsp_pend_q[0];
  assign rsp1_valid_o   = rst_n & rsp_pend_q[1];
  assign rsp0_rdata_o   = rsp0_valid_o ? mem_rdata_i : 32'h0;
  assign rsp1_rdata_o   = rsp1_valid_o ? mem_rdata_i : 32'h0;
  assign busy_o         = rst_n & (state_q == S_HOLD1);
  assign conflict_cnt_o = rst_n ? cnt_q : '0;
  assign err_o          = rst_n & err_q;

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, byte-address width of requests and memory port.
REQ-002 Parameter: CNT_W, 16, width of the saturating conflict counter.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 req0_valid / req1_valid  in  1  slot0 (older) / slot1 (younger) memory request.
REQ-007 req0_ready / req1_ready  out  1  request accepted this cycle.
REQ-008 reqN_addr  in  ADDR_W  byte address; reqN_wdata  in  32  store data.
REQ-009 reqN_we  in  4  byte write enables; reqN_re  in  1  read enable.
REQ-010 rspN_valid  out  1  read-data pulse; rspN_rdata  out  32  read data.
REQ-011 mem_addr  out  ADDR_W; mem_wdata  out  32; mem_we  out  4; mem_re  out  1; mem_rdata  in  32; memory returns read data one cycle after mem_re.
REQ-012 busy  out  1  high while in HOLD1.
REQ-013 conflict_cnt  out  CNT_W  count of dual-request cycles.
REQ-014 err  out  1  sticky: a request with re=1 and we!=0 was accepted.

Function
REQ-015 FSM states: IDLE, HOLD1.
REQ-016 IDLE, only req0_valid: drive req0 onto memory port combinationally, req0_ready=1, stay IDLE.
REQ-017 IDLE, only req1_valid: drive req1 onto memory port, req1_ready=1, stay IDLE.
REQ-018 IDLE, both valid: issue req0 this cycle, latch req1 (addr, wdata, we, re) into hold register, both ready=1, increment conflict_cnt, go HOLD1.
REQ-019 HOLD1: drive hold register onto memory port, req0_ready=req1_ready=0, go IDLE next cycle regardless of inputs.
REQ-020 Ordering: slot0 SHALL always reach the memory port no later than a same-cycle slot1 request (program order preserved, incl. same-address RAW/WAW).
REQ-021 Request with we!=0 SHALL be issued as a write with mem_re=0, and SHALL set err if re=1; err clears only on reset.
REQ-022 Request with re=0 and we=0 SHALL be accepted, issue no access (mem_re=0, mem_we=0), produce no response.
REQ-023 With no access issued, mem_addr, mem_wdata, mem_we, mem_re SHALL be 0.
REQ-024 Each issued read SHALL produce exactly one rspN_valid pulse, on the requesting slot only, exactly one cycle after its mem_re cycle, with rspN_rdata = mem_rdata of that cycle; rspN_rdata SHALL be 0 when rspN_valid=0.
REQ-025 Writes SHALL produce no response.
REQ-026 Read-to-response latency: 1 cycle for non-conflicting requests; 2 cycles for a slot1 read deferred via HOLD1.
REQ-027 conflict_cnt SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-028 Requests SHALL be sampled only in cycles where their ready is 1; requesters hold valid and payload until ready.

Reset
REQ-029 While rst_n=0 at a rising edge: state=IDLE, hold register=0, pending response=none, conflict_cnt=0, err=0.
REQ-030 During and after reset, all outputs SHALL be 0, including both ready signals while rst_n=0.
REQ-031 Reset asserted in HOLD1 SHALL discard the held request: no memory access and no response for it after reset.
REQ-032 Reset asserted one cycle after a read issue SHALL suppress that read's response.

Verification
REQ-033 Single read: req0 re=1 addr=0x100, mem_rdata=0xDEADBEEF next cycle -> mem_re=1 addr=0x100 in cycle 0; rsp0_valid=1, rdata=0xDEADBEEF in cycle 1; rsp1_valid=0.
REQ-034 Dual request: req0 write we=0xF addr=0x200 wdata=0x11, req1 read addr=0x200 -> cycle 0 write issued, both ready, busy=0; cycle 1 busy=1, mem_re addr=0x200, readies 0; cycle 2 rsp1_valid=1; conflict_cnt=1.
REQ-035 Back-to-back conflicts: both valid every cycle for 6 cycles -> accepts alternate (IDLE/HOLD1), 6 memory accesses in order 0,1,0,1,0,1, conflict_cnt=3.
REQ-036 Saturation with CNT_W=2: 5 conflicts -> conflict_cnt=3.
REQ-037 Reset in HOLD1: both valid, rst_n=0 next cycle -> no mem access for held slot1 request, no rsp1_valid, all outputs 0, counter 0.
REQ-038 Error: req1 with re=1, we=0x3 -> mem_we=0x3, mem_re=0, no response, err=1 and stays 1 until rst_n=0.
